// File: rtl/pearson_pkg.sv
// pearson_pkg: Pearson permutation table, stream FSM states and lane limit shared by the hash blocks
package pearson_pkg;
    localparam int MAX_LANES = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [7:0] PERM [256] = '{
         98,   6,  85, 150,  36,  23, 112, 164, 135, 207, 169,   5,  26,  64, 165, 219,
         61,  20,  68,  89, 130,  63,  52, 102,  24, 229, 132, 245,  80, 216, 195, 115,
         90, 168, 156, 203, 177, 120,   2, 190, 188,   7, 100, 185, 174, 243, 162,  10,
        237,  18, 253, 225,   8, 208, 172, 244, 255, 126, 101,  79, 145, 235, 228, 121,
        123, 251,  67, 250, 161,   0, 107,  97, 241, 111, 181,  82, 249,  33,  69,  55,
         59, 153,  29,   9, 213, 167,  84,  93,  30,  46,  94,  75, 151, 114,  73, 222,
        197,  96, 210,  45,  16, 227, 248, 202,  51, 152, 252, 125,  81, 206, 215, 186,
         39, 158, 178, 187, 131, 136,   1,  49,  50,  17, 141,  91,  47, 129,  60,  99,
        154,  35,  86, 171, 105,  34,  38, 200, 147,  58,  77, 118, 173, 246,  76, 254,
        133, 232, 196, 144, 198, 124,  53,   4, 108,  74, 223, 234, 134, 230, 157, 139,
        189, 205, 199, 128, 176,  19, 211, 236, 127, 192, 231,  70, 233,  88, 146,  44,
        183, 201,  22,  83,  13, 214, 116, 109, 159,  32,  95, 226, 140, 220,  57,  12,
        221,  31, 209, 182, 143,  92, 149, 184, 148,  62, 113,  65,  37,  27, 106, 166,
          3,  14, 204,  72,  21,  41,  56,  66,  28, 193,  40, 217,  25,  54, 179, 117,
        238,  87, 240, 155, 180, 170, 242, 212, 191, 163,  78, 218, 137, 194, 175, 110,
         43, 119, 224,  71, 122, 142,  42, 160, 104,  48, 247, 103,  15,  11, 138, 239
    };
endpackage

// File: rtl/pearson_stream_if.sv
// pearson_stream_if: key byte stream in (in_data/in_valid/in_last/in_ready), result out (hash/key_len/len_ovf/hash_valid/hash_ready)
interface pearson_stream_if #(parameter int HASH_BYTES = 1, parameter int LEN_W = 16);
    logic [7:0] in_data;
    logic in_valid, in_last, in_ready;
    logic [8*HASH_BYTES-1:0] hash;
    logic [LEN_W-1:0] key_len;
    logic len_ovf, hash_valid, hash_ready;
    modport slave (input in_data, in_valid, in_last, hash_ready, output in_ready, hash, key_len, len_ovf, hash_valid);
    modport master (output in_data, in_valid, in_last, hash_ready, input in_ready, hash, key_len, len_ovf, hash_valid);
endinterface

// File: rtl/pearson_lane.sv
// pearson_lane: one 8-bit hash lane; ports clk, rst_n, clr, load (byte accepted), first (key start), data, h
module pearson_lane import pearson_pkg::*; #(parameter int LANE = 0) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       first,
    input  logic [7:0] data,
    output logic [7:0] h
);
    logic [7:0] idx;
    assign idx = first ? data + 8'(LANE) : h ^ data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) h <= '0;
        else if (clr) h <= '0;
        else if (load) h <= PERM[idx];
endmodule

// File: rtl/pearson_stream.sv
// pearson_stream: streaming multi-lane Pearson hash; ports clk, rst_n, clr (sync abort) and stream interface s
module pearson_stream import pearson_pkg::*; #(
    parameter int HASH_BYTES = 1,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst_n,
    input logic clr,
    pearson_stream_if.slave s
);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    state_t state, next;
    logic accept, first, ovf;
    logic [LEN_W-1:0] len;
    logic [8*HASH_BYTES-1:0] lanes;
    // DONE only accepts a byte when the held result leaves in the same cycle
    assign s.in_ready = !clr && (state != DONE || s.hash_ready);
    assign accept = s.in_valid && s.in_ready;
    // IDLE and DONE both start a fresh key on the next accepted byte
    assign first = state != ACCUM;
    assign s.hash_valid = state == DONE && !clr;
    assign s.hash = lanes;
    assign s.key_len = len;
    assign s.len_ovf = ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        if (clr) next = IDLE;
        else if (accept) next = s.in_last ? DONE : ACCUM;
        else if (state == DONE && s.hash_ready) next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            len <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            len <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            len <= first ? LEN_ONE : (len == LEN_MAX ? len : len + LEN_ONE);
            ovf <= !first && (ovf || len == LEN_MAX);
        end
    for (genvar i = 0; i < HASH_BYTES; i++) begin : g_lane
        pearson_lane #(.LANE(i)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .clr(clr),
            .load(accept),
            .first(first),
            .data(s.in_data),
            .h(lanes[8*i +: 8])
        );
    end
endmodule

// File: tb/tb_pearson_stream.sv
// tb_pearson_stream: directed and random checks of pearson_stream against a queue-based Pearson reference
module tb_pearson_stream;
    import pearson_pkg::*;
    typedef logic [7:0] byte_q_t [$];
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0, in_last = 1'b0, hash_ready = 1'b1;
    int compared = 0, mismatched = 0;
    byte_q_t key, done_key;
    logic [7:0] hello [8] = '{8'd108, 8'd101, 8'd104, 8'd111, 8'd108, 8'd108, 8'd101, 8'd104};
    pearson_stream_if #(.HASH_BYTES(1), .LEN_W(16)) ifa ();
    pearson_stream_if #(.HASH_BYTES(4), .LEN_W(3)) ifb ();
    assign ifa.in_data = in_data;
    assign ifa.in_valid = in_valid;
    assign ifa.in_last = in_last;
    assign ifa.hash_ready = hash_ready;
    assign ifb.in_data = in_data;
    assign ifb.in_valid = in_valid;
    assign ifb.in_last = in_last;
    assign ifb.hash_ready = hash_ready;
    pearson_stream #(.HASH_BYTES(1), .LEN_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .s(ifa));
    pearson_stream #(.HASH_BYTES(4), .LEN_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .s(ifb));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end
    function automatic logic [31:0] model_hash(input byte_q_t k);
        logic [31:0] r;
        logic [7:0] h;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            h = PERM[k[0] + 8'(i)];
            for (int j = 1; j < k.size(); j++) h = PERM[h ^ k[j]];
            r[8*i +: 8] = h;
        end
        return r;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_result(input byte_q_t k);
        logic [31:0] e;
        int n;
        e = model_hash(k);
        n = k.size();
        chk("valid", 64'({ifa.hash_valid, ifb.hash_valid}), 64'(2'b11));
        chk("hash_a", 64'(ifa.hash), 64'(e[7:0]));
        chk("hash_b", 64'(ifb.hash), 64'(e));
        chk("len_a", 64'(ifa.key_len), 64'(n));
        chk("len_b", 64'(ifb.key_len), 64'(n > 7 ? 7 : n));
        chk("ovf_a", 64'(ifa.len_ovf), 64'(0));
        chk("ovf_b", 64'(ifb.len_ovf), 64'(n > 7));
    endtask
    task automatic send_byte(input logic [7:0] b, input logic last);
        in_data = b;
        in_last = last;
        in_valid = 1'b1;
        #1 chk("in_ready", 64'({ifa.in_ready, ifb.in_ready}), 64'(2'b11));
        @(posedge clk);
        #1;
        key.push_back(b);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        if (last) begin
            check_result(key);
            done_key = key;
            key.delete();
        end else chk("busy", 64'({ifa.hash_valid, ifb.hash_valid}), 64'(0));
    endtask
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(posedge clk);
            #1 chk("idle_valid", 64'({ifa.hash_valid, ifb.hash_valid}), 64'(0));
        end
    endtask
    task automatic stall(input int n);
        hash_ready = 1'b0;
        in_valid = 1'b1;
        repeat (n) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            #1 chk("stall_ready", 64'({ifa.in_ready, ifb.in_ready}), 64'(0));
            @(posedge clk);
            #1 check_result(done_key);
        end
        in_valid = 1'b0;
        hash_ready = 1'b1;
    endtask
    task automatic send_key(input int n);
        for (int j = 0; j < n; j++) send_byte(8'($urandom), j == n - 1);
    endtask
    initial begin
        #12;
        chk("rst_valid", 64'({ifa.hash_valid, ifb.hash_valid}), 64'(0));
        chk("rst_hash", 64'({ifa.hash, ifb.hash}), 64'(0));
        chk("rst_len", 64'({ifa.key_len, ifb.key_len, ifa.len_ovf, ifb.len_ovf}), 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(hello[i], i == 7);
        idle(1);
        send_byte(8'h00, 1'b1);
        chk("lanes_t", 64'(ifb.hash), 64'({PERM[3], PERM[2], PERM[1], PERM[0]}));
        stall(5);
        send_key(3);
        idle(2);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        #1 chk("clr_ready", 64'({ifa.in_ready, ifb.in_ready}), 64'(0));
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        key.delete();
        chk("clr_state", 64'({ifa.hash_valid, ifb.hash_valid, ifa.key_len, ifb.key_len, ifb.len_ovf}), 64'(0));
        chk("clr_hash", 64'({ifa.hash, ifb.hash}), 64'(0));
        for (int i = 0; i < 8; i++) send_byte(hello[i], i == 7);
        send_key(9);
        send_key(2);
        idle(1);
        repeat (12) begin
            int n;
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_byte(8'($urandom), j == n - 1);
            end
            if ($urandom_range(0, 1) == 1) stall($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'({ifa.hash_valid, ifb.hash_valid, ifa.key_len, ifb.key_len}), 64'(0));
        chk("arst_hash", 64'({ifa.hash, ifb.hash}), 64'(0));
        key.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(hello[i], i == 7);
        idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
